// File: rtl/tone_seq_gen_if.sv
// Control/status bundle for the buzzer tone sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start/stop/wr_en are single-cycle pulses sampled on clk.
interface tone_seq_gen_if #(
    parameter int PERIOD_W = 20,
    parameter int DUR_W    = 26,
    parameter int ADDR_W   = 3
);
    logic [1:0]          mode;
    logic [ADDR_W-1:0]   last_idx;
    logic                start;
    logic                stop;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [PERIOD_W-1:0] wr_half;
    logic [DUR_W-1:0]    wr_dur;
    logic                beep;
    logic                busy;
    logic [ADDR_W-1:0]   note_idx;
    logic                done;

    // Controller side: issues commands and table writes, watches status.
    modport master (
        output mode, last_idx, start, stop, wr_en, wr_addr, wr_half, wr_dur,
        input  beep, busy, note_idx, done
    );

    // Sequencer side.
    modport slave (
        input  mode, last_idx, start, stop, wr_en, wr_addr, wr_half, wr_dur,
        output beep, busy, note_idx, done
    );
endinterface

// File: rtl/tone_seq_gen.sv
// Buzzer tone sequencer: plays a note table (half-period, duration) as a square wave.
// Latency: start -> LOAD next cycle; each note = 1 LOAD + max(dur,1) PLAY cycles.
// Backpressure: none; start is ignored while busy, stop aborts immediately.
module tone_seq_gen #(
    parameter int PERIOD_W = 20,
    parameter int DUR_W    = 26,
    parameter int ADDR_W   = 3
) (
    input  logic          clk,
    input  logic          rst,
    tone_seq_gen_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Note table: plain register storage, deliberately not cleared by rst.
    logic [PERIOD_W-1:0] tbl_half [DEPTH];
    logic [DUR_W-1:0]    tbl_dur  [DEPTH];

    // Working copy of the note being played, so table writes never disturb it.
    logic [PERIOD_W-1:0] hp;
    logic [PERIOD_W-1:0] per_cnt;
    logic [DUR_W-1:0]    dur_cnt;
    logic [1:0]          mode_l;
    logic [ADDR_W-1:0]   last_l;
    logic [ADDR_W-1:0]   note_idx;
    logic                beep;
    logic                done;

    logic tone_mode;
    logic loop_mode;
    logic more_notes;
    logic note_end;
    logic go;

    // Mode 11 falls through to one-shot because only 00 and 10 are decoded.
    assign tone_mode  = (mode_l == 2'b00);
    assign loop_mode  = (mode_l == 2'b10);
    assign more_notes = (note_idx < last_l);
    assign note_end   = (state == S_PLAY) && !tone_mode && (dur_cnt == DUR_W'(1));
    assign go         = bus.start && !bus.stop;

    // Table write port; a write in the same cycle as rst is discarded.
    always_ff @(posedge clk) begin
        if (bus.wr_en && !rst) begin
            tbl_half[bus.wr_addr] <= bus.wr_half;
            tbl_dur[bus.wr_addr]  <= bus.wr_dur;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: stop always wins; a one-shot ends after its last note.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = bus.stop ? S_IDLE : S_PLAY;
            end
            S_PLAY: begin
                if (bus.stop) begin
                    state_nxt = S_IDLE;
                end else if (note_end) begin
                    state_nxt = (loop_mode || more_notes) ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: note loading, half-period/duration counting and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            hp       <= '0;
            per_cnt  <= '0;
            dur_cnt  <= '0;
            mode_l   <= '0;
            last_l   <= '0;
            note_idx <= '0;
            beep     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    beep <= 1'b0;
                    if (go) begin
                        note_idx <= '0;
                        mode_l   <= bus.mode;
                        last_l   <= bus.last_idx;
                    end
                end
                S_LOAD: begin
                    beep <= 1'b0;
                    if (bus.stop) begin
                        note_idx <= '0;
                    end else begin
                        hp      <= tbl_half[note_idx];
                        per_cnt <= '0;
                        dur_cnt <= (tbl_dur[note_idx] == '0) ? DUR_W'(1) : tbl_dur[note_idx];
                    end
                end
                S_PLAY: begin
                    if (bus.stop) begin
                        beep     <= 1'b0;
                        note_idx <= '0;
                    end else begin
                        // A zero half-period is a rest: output held low, counter parked.
                        if (hp == '0) begin
                            beep    <= 1'b0;
                            per_cnt <= '0;
                        end else if (per_cnt == hp - PERIOD_W'(1)) begin
                            beep    <= ~beep;
                            per_cnt <= '0;
                        end else begin
                            per_cnt <= per_cnt + PERIOD_W'(1);
                        end

                        if (!tone_mode) begin
                            dur_cnt <= dur_cnt - DUR_W'(1);
                        end

                        if (note_end) begin
                            if (more_notes) begin
                                note_idx <= note_idx + ADDR_W'(1);
                            end else if (loop_mode) begin
                                note_idx <= '0;
                            end else begin
                                beep <= 1'b0;
                                done <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    beep <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs.
    always_comb begin
        bus.busy     = (state != S_IDLE);
        bus.beep     = beep;
        bus.note_idx = note_idx;
        bus.done     = done;
    end
endmodule

// File: tb/tb_tone_seq_gen.sv
// Self-checking bench for tone_seq_gen against a note/offset reference model.
module tb_tone_seq_gen;
    localparam int PW = 20;
    localparam int DW = 26;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tone_seq_gen_if #(.PERIOD_W(PW), .DUR_W(DW), .ADDR_W(AW)) bus ();

    tone_seq_gen #(.PERIOD_W(PW), .DUR_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: position within playback = (note n, offset k),
    // k = 0 for the LOAD cycle and 1..D for the PLAY cycles of the note.
    int m_half [8];
    int m_dur  [8];
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    bit m_load_beep = 1'b0;
    int m_n = 0, m_k = 0, m_H = 0, m_D = 1, m_mode = 0, m_last = 0;

    // Playback monitor for directed timing checks.
    int cyc, ndone, first_done, first_beep;

    function automatic bit exp_beep();
        if (!m_active) return 1'b0;
        if (m_k == 0) return m_load_beep;
        if (m_H == 0) return 1'b0;
        return (((m_k - 1) / m_H) % 2) == 1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT sampled.
    task automatic model_step();
        if (rst) begin
            m_active = 1'b0; m_done = 1'b0; m_n = 0; m_k = 0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (bus.start && !bus.stop) begin
                    m_active = 1'b1; m_n = 0; m_k = 0; m_load_beep = 1'b0;
                    m_mode = (bus.mode == 2'd3) ? 1 : int'(bus.mode);
                    m_last = int'(bus.last_idx);
                end
            end else if (bus.stop) begin
                m_active = 1'b0; m_n = 0;
            end else if (m_k == 0) begin
                m_H = m_half[m_n];
                m_D = (m_dur[m_n] == 0) ? 1 : m_dur[m_n];
                m_k = 1;
            end else if (m_mode != 0 && m_k == m_D) begin
                // Level left on the pin after D PLAY cycles of half-period H.
                m_load_beep = (m_H != 0) && (((m_D / m_H) % 2) == 1);
                if (m_n < m_last) begin
                    m_n++; m_k = 0;
                end else if (m_mode == 2) begin
                    m_n = 0; m_k = 0;
                end else begin
                    m_active = 1'b0; m_done = 1'b1;
                end
            end else begin
                m_k++;
            end
            if (bus.wr_en) begin
                m_half[int'(bus.wr_addr)] = int'(bus.wr_half);
                m_dur[int'(bus.wr_addr)]  = int'(bus.wr_dur);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("busy", int'(bus.busy), int'(m_active));
        check("beep", int'(bus.beep), int'(exp_beep()));
        check("done", int'(bus.done), int'(m_done));
        if (m_active) check("note_idx", int'(bus.note_idx), m_n);
        cyc++;
        if (bus.done) begin
            ndone++;
            if (first_done < 0) first_done = cyc;
        end
        if (bus.beep && first_beep < 0) first_beep = cyc;
        rst = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.wr_en = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic write_note(input int a, input int h, input int d);
        bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_half = PW'(h); bus.wr_dur = DW'(d);
        tick();
    endtask

    // Start playback; the cycle after the start edge is counted as t1.
    task automatic play(input int mode, input int last);
        bus.mode = 2'(mode); bus.last_idx = AW'(last); bus.start = 1'b1;
        cyc = 0; ndone = 0; first_done = -1; first_beep = -1;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.mode = 2'd0; bus.last_idx = '0; bus.start = 1'b0; bus.stop = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_half = '0; bus.wr_dur = '0;
        for (int i = 0; i < 8; i++) begin m_half[i] = 0; m_dur[i] = 0; end
        tick();
        rst = 1'b1;
        tick();
        check("reset_note_idx", int'(bus.note_idx), 0);
        check("reset_busy", int'(bus.busy), 0);

        // 1: single note, one-shot.
        write_note(0, 3, 12);
        play(1, 0);
        check("t1_busy_at_t1", int'(bus.busy), 1);
        run(19);
        check("t1_first_rise", first_beep, 5);
        check("t1_done_cycle", first_done, 14);
        check("t1_done_count", ndone, 1);

        // 2: rest followed by a tone.
        write_note(0, 0, 5);
        write_note(1, 2, 4);
        play(1, 1);
        run(16);
        check("t2_first_rise", first_beep, 10);
        check("t2_done_cycle", first_done, 12);
        check("t2_done_count", ndone, 1);

        // 3: loop over three notes, stopped mid-note.
        write_note(0, 2, 4);
        write_note(1, 3, 6);
        write_note(2, 1, 2);
        play(2, 2);
        run(30);
        bus.stop = 1'b1;
        run(1);
        check("t3_stop_busy", int'(bus.busy), 0);
        check("t3_stop_beep", int'(bus.beep), 0);
        run(5);
        check("t3_done_count", ndone, 0);

        // 4: continuous tone, long run, then stop.
        write_note(0, 5, 1);
        play(0, 3);
        run(1100);
        check("t4_done_count", ndone, 0);
        check("t4_still_busy", int'(bus.busy), 1);
        bus.stop = 1'b1;
        run(3);
        check("t4_stopped", int'(bus.busy), 0);

        // 5: reset mid-play, table survives and replays.
        write_note(0, 3, 5);
        write_note(1, 2, 3);
        play(1, 1);
        run(6);
        rst = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = AW'(1); bus.wr_half = PW'(7); bus.wr_dur = DW'(9);
        run(1);
        check("t5_rst_note_idx", int'(bus.note_idx), 0);
        check("t5_rst_busy", int'(bus.busy), 0);
        play(1, 1);
        run(20);
        check("t5_done_cycle", first_done, 11);
        check("t5_done_count", ndone, 1);

        // 6: start while busy, write to playing entry, start+stop in IDLE.
        write_note(0, 2, 4);
        write_note(1, 3, 6);
        write_note(2, 1, 2);
        play(2, 2);
        run(3);
        bus.start = 1'b1;
        run(4);
        bus.wr_en = 1'b1; bus.wr_addr = AW'(m_n); bus.wr_half = PW'(4); bus.wr_dur = DW'(7);
        run(40);
        bus.stop = 1'b1;
        run(2);
        bus.start = 1'b1; bus.stop = 1'b1;
        run(1);
        check("t6_start_stop_idle", int'(bus.busy), 0);
        run(2);

        // Randomized tables and modes.
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 8; a++) begin
                write_note(a, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
            end
            play((r == 0) ? 3 : int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            run(70);
            bus.stop = 1'b1;
            run(3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
